// File: rtl/apb_wb_pkg.sv
// Shared types and constants for the APB-to-Wishbone bridge.
// The optional Wishbone timeout is enabled by defining APB_WB_BRIDGE_TIMEOUT_EN.
package apb_wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WB_WAIT = 2'd1,
        ST_RESP    = 2'd2
    } state_e;

    localparam int          MAX_SLAVES   = 8;
    localparam int          IDX_W        = 3;
    localparam int          TO_CNT_W     = 16;
    localparam logic [31:0] DEFAULT_MASK = 32'hFFF0_0000;

endpackage

// File: rtl/apb_wb_bridge_n_if.sv
// APB and multi-port Wishbone bus bundles for the bridge.
// The bridge uses apb_if.slave and wb_if.master; the environment takes the opposite modports.
interface apb_if #(
    parameter int W_ADDR = 32,
    parameter int W_DATA = 32
);
    logic [W_ADDR-1:0]   paddr;
    logic                psel;
    logic                penable;
    logic                pwrite;
    logic [W_DATA-1:0]   pwdata;
    logic [W_DATA/8-1:0] pstrb;
    logic                pready;
    logic [W_DATA-1:0]   prdata;
    logic                pslverr;

    modport master (output paddr, psel, penable, pwrite, pwdata, pstrb,
                    input  pready, prdata, pslverr);
    modport slave  (input  paddr, psel, penable, pwrite, pwdata, pstrb,
                    output pready, prdata, pslverr);
endinterface

interface wb_if #(
    parameter int N_SLAVES = 2,
    parameter int W_ADDR   = 32,
    parameter int W_DATA   = 32
);
    logic [N_SLAVES-1:0]        wb_cyc_o;
    logic [N_SLAVES-1:0]        wb_stb_o;
    logic                       wb_we_o;
    logic [W_DATA/8-1:0]        wb_sel_o;
    logic [W_ADDR-1:0]          wb_adr_o;
    logic [W_DATA-1:0]          wb_dat_o;
    logic [N_SLAVES*W_DATA-1:0] wb_dat_i;
    logic [N_SLAVES-1:0]        wb_ack_i;
    logic [N_SLAVES-1:0]        wb_err_i;

    modport master (output wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o,
                    input  wb_dat_i, wb_ack_i, wb_err_i);
    modport slave  (input  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o,
                    output wb_dat_i, wb_ack_i, wb_err_i);
endinterface

// File: rtl/apb_wb_decoder.sv
// Combinational address decoder: one-hot hit vector and index of the lowest matching slave.
module apb_wb_decoder
    import apb_wb_pkg::*;
#(
    parameter int                         N_SLAVES  = 2,
    parameter int                         W_ADDR    = 32,
    parameter logic [N_SLAVES*W_ADDR-1:0] ADDR_MAP  = {32'h2610_0000, 32'h2600_0000},
    parameter logic [N_SLAVES*W_ADDR-1:0] ADDR_MASK = {DEFAULT_MASK, DEFAULT_MASK}
) (
    input  logic [W_ADDR-1:0]   addr,
    output logic [N_SLAVES-1:0] hit,
    output logic [IDX_W-1:0]    idx,
    output logic                hit_any
);

    logic [N_SLAVES-1:0] raw_s;

    // Per-slave match, then keep only the first (lowest) match in ascending order
    always_comb begin
        raw_s   = '0;
        hit     = '0;
        idx     = '0;
        hit_any = 1'b0;
        for (int i = 0; i < N_SLAVES; i++) begin
            raw_s[i] = ((addr & ADDR_MASK[i*W_ADDR +: W_ADDR]) ==
                        (ADDR_MAP[i*W_ADDR +: W_ADDR] & ADDR_MASK[i*W_ADDR +: W_ADDR]));
        end
        for (int i = 0; i < N_SLAVES; i++) begin
            hit[i]  = raw_s[i] & ~hit_any;
            idx     = (raw_s[i] & ~hit_any) ? IDX_W'(i) : idx;
            hit_any = hit_any | raw_s[i];
        end
    end

endmodule

// File: rtl/apb_wb_bridge_n.sv
// APB slave to N-port Wishbone master bridge with registered outputs.
// Define APB_WB_BRIDGE_TIMEOUT_EN to abort Wishbone cycles after TIMEOUT_CYCLES clocks.
module apb_wb_bridge_n
    import apb_wb_pkg::*;
#(
    parameter int                         N_SLAVES       = 2,
    parameter int                         W_ADDR         = 32,
    parameter int                         W_DATA         = 32,
    parameter logic [N_SLAVES*W_ADDR-1:0] ADDR_MAP       = {32'h2610_0000, 32'h2600_0000},
    parameter logic [N_SLAVES*W_ADDR-1:0] ADDR_MASK      = {DEFAULT_MASK, DEFAULT_MASK},
    parameter int                         TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    apb_if.slave apb,
    wb_if.master wb
);

    localparam int W_STRB = W_DATA / 8;

    if (N_SLAVES < 1 || N_SLAVES > MAX_SLAVES || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
        $error("apb_wb_bridge_n: N_SLAVES or TIMEOUT_CYCLES out of range");
    end

    state_e              state_r, state_s;
    logic [N_SLAVES-1:0] cyc_r, cyc_s;
    logic [IDX_W-1:0]    idx_r, idx_s;
    logic                we_r, we_s;
    logic [W_STRB-1:0]   sel_r, sel_s;
    logic [W_ADDR-1:0]   adr_r, adr_s;
    logic [W_DATA-1:0]   dat_r, dat_s;
    logic                abort_r, abort_s;
    logic                pready_r, pready_s;
    logic [W_DATA-1:0]   prdata_r, prdata_s;
    logic                pslverr_r, pslverr_s;

    logic [N_SLAVES-1:0] dec_hit_s;
    logic [IDX_W-1:0]    dec_idx_s;
    logic                dec_any_s;
    logic                ack_s, err_s, expire_s;
    logic [W_DATA-1:0]   rdat_s;

    apb_wb_decoder #(
        .N_SLAVES  (N_SLAVES),
        .W_ADDR    (W_ADDR),
        .ADDR_MAP  (ADDR_MAP),
        .ADDR_MASK (ADDR_MASK)
    ) u_decoder (
        .addr    (apb.paddr),
        .hit     (dec_hit_s),
        .idx     (dec_idx_s),
        .hit_any (dec_any_s)
    );

    // Response lines of the selected port only; other ports are ignored
    always_comb begin
        ack_s  = 1'b0;
        err_s  = 1'b0;
        rdat_s = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            ack_s  = ack_s | (wb.wb_ack_i[i] & (idx_r == IDX_W'(i)));
            err_s  = err_s | (wb.wb_err_i[i] & (idx_r == IDX_W'(i)));
            rdat_s = rdat_s | (wb.wb_dat_i[i*W_DATA +: W_DATA] & {W_DATA{idx_r == IDX_W'(i)}});
        end
    end

`ifdef APB_WB_BRIDGE_TIMEOUT_EN
    logic [TO_CNT_W-1:0] cnt_r;

    assign expire_s = (cnt_r == TO_CNT_W'(TIMEOUT_CYCLES - 1));

    // Clocks spent in WB_WAIT for the current cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (state_r == ST_WB_WAIT && !(ack_s || err_s || expire_s)) begin
            cnt_r <= cnt_r + 16'd1;
        end else begin
            cnt_r <= '0;
        end
    end
`else
    assign expire_s = 1'b0;
`endif

    // Next-state and next-output logic
    always_comb begin
        state_s   = state_r;
        cyc_s     = cyc_r;
        idx_s     = idx_r;
        we_s      = we_r;
        sel_s     = sel_r;
        adr_s     = adr_r;
        dat_s     = dat_r;
        abort_s   = abort_r;
        pready_s  = 1'b0;
        prdata_s  = '0;
        pslverr_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                abort_s = 1'b0;
                if (apb.psel && apb.penable) begin
                    if (dec_any_s) begin
                        state_s = ST_WB_WAIT;
                        cyc_s   = dec_hit_s;
                        idx_s   = dec_idx_s;
                        we_s    = apb.pwrite;
                        sel_s   = apb.pwrite ? apb.pstrb : '1;
                        adr_s   = apb.paddr;
                        dat_s   = apb.pwdata;
                    end else begin
                        state_s   = ST_RESP;
                        pready_s  = 1'b1;
                        pslverr_s = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WB_WAIT: begin
                // A master that walks away still gets its Wishbone cycle finished, silently
                abort_s = abort_r | ~apb.psel;
                if (ack_s || err_s || expire_s) begin
                    cyc_s = '0;
                    if (abort_s) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s   = ST_RESP;
                        pready_s  = 1'b1;
                        pslverr_s = err_s | ~ack_s;
                        prdata_s  = (ack_s && !err_s && !we_r) ? rdat_s : '0;
                    end
                end else begin
                    state_s = ST_WB_WAIT;
                end
            end
            ST_RESP: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
                cyc_s   = '0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            cyc_r     <= '0;
            idx_r     <= '0;
            we_r      <= 1'b0;
            sel_r     <= '0;
            adr_r     <= '0;
            dat_r     <= '0;
            abort_r   <= 1'b0;
            pready_r  <= 1'b0;
            prdata_r  <= '0;
            pslverr_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            cyc_r     <= cyc_s;
            idx_r     <= idx_s;
            we_r      <= we_s;
            sel_r     <= sel_s;
            adr_r     <= adr_s;
            dat_r     <= dat_s;
            abort_r   <= abort_s;
            pready_r  <= pready_s;
            prdata_r  <= prdata_s;
            pslverr_r <= pslverr_s;
        end
    end

    assign wb.wb_cyc_o = cyc_r;
    assign wb.wb_stb_o = cyc_r;
    assign wb.wb_we_o  = we_r;
    assign wb.wb_sel_o = sel_r;
    assign wb.wb_adr_o = adr_r;
    assign wb.wb_dat_o = dat_r;
    assign apb.pready  = pready_r;
    assign apb.prdata  = prdata_r;
    assign apb.pslverr = pslverr_r;

endmodule

// File: tb/tb_apb_wb_bridge_n.sv
// Scoreboard bench for apb_wb_bridge_n: expected APB responses are queued per transfer
// and compared when pready rises; a Wishbone responder model serves both ports.
module tb_apb_wb_bridge_n;

    localparam int M_ACK   = 0;
    localparam int M_ERR   = 1;
    localparam int M_BOTH  = 2;
    localparam int M_NEVER = 3;

    typedef struct {
        logic        err;
        logic [31:0] data;
    } exp_t;

    logic clk;
    logic rst_n;

    apb_if #(.W_ADDR(32), .W_DATA(32)) apb_i ();
    wb_if  #(.N_SLAVES(2), .W_ADDR(32), .W_DATA(32)) wb_i ();

    // Slave 1 mask is widened so 0x26000000..0x260FFFFF hits both ports
    apb_wb_bridge_n #(
        .N_SLAVES       (2),
        .W_ADDR         (32),
        .W_DATA         (32),
        .ADDR_MAP       ({32'h2610_0000, 32'h2600_0000}),
        .ADDR_MASK      ({32'hFF00_0000, 32'hFFF0_0000}),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .apb   (apb_i),
        .wb    (wb_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    string       cur_tag  = "init";
    exp_t        exp_q[$];
    int          resp_mode  = M_ACK;
    int          resp_delay = 0;
    logic        stray_en   = 1'b0;
    int          cyc_cycles = 0;
    logic [1:0]  seen_cyc   = 2'b00;
    logic        cap_we     = 1'b0;
    logic [3:0]  cap_sel    = 4'h0;
    logic [31:0] cap_adr    = 32'h0;
    logic [31:0] cap_dat    = 32'h0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", cur_tag, tag, got, exp);
        end
    endtask

    // Wishbone responder: acks/errs the selected port after resp_delay stb cycles
    initial begin
        int          stb_cnt;
        logic        acked;
        logic [1:0]  ack_v;
        logic [1:0]  err_v;
        stb_cnt = 0;
        acked   = 1'b0;
        wb_i.wb_ack_i = 2'b00;
        wb_i.wb_err_i = 2'b00;
        wb_i.wb_dat_i = 64'h0;
        forever begin
            @(negedge clk);
            ack_v = 2'b00;
            err_v = 2'b00;
            if (|wb_i.wb_cyc_o) begin
                if (!acked && resp_mode != M_NEVER && stb_cnt >= resp_delay) begin
                    if (resp_mode != M_ERR) ack_v = wb_i.wb_stb_o;
                    if (resp_mode != M_ACK) err_v = wb_i.wb_stb_o;
                    acked = 1'b1;
                end
                stb_cnt++;
            end else begin
                stb_cnt = 0;
                acked   = 1'b0;
            end
            if (stray_en) begin
                ack_v = ack_v | ~wb_i.wb_cyc_o;
                err_v = err_v | ~wb_i.wb_cyc_o;
            end
            wb_i.wb_ack_i = ack_v;
            wb_i.wb_err_i = err_v;
        end
    end

    // Wishbone capture and APB scoreboard compare
    always @(negedge clk) begin
        if (|wb_i.wb_cyc_o) begin
            cyc_cycles++;
            seen_cyc = seen_cyc | wb_i.wb_cyc_o;
            cap_we   = wb_i.wb_we_o;
            cap_sel  = wb_i.wb_sel_o;
            cap_adr  = wb_i.wb_adr_o;
            cap_dat  = wb_i.wb_dat_o;
            check("stb_eq_cyc", 64'(wb_i.wb_stb_o), 64'(wb_i.wb_cyc_o));
        end
        if (rst_n && apb_i.pready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pready", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("pslverr", 64'(apb_i.pslverr), 64'(e.err));
                check("prdata", 64'(apb_i.prdata), 64'(e.data));
            end
        end
    end

    task automatic apb_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                            input logic [3:0] strb, input logic exp_err, input logic [31:0] exp_data,
                            input int exp_lat, input int exp_cyc);
        int n;
        exp_q.push_back('{err: exp_err, data: exp_data});
        cyc_cycles = 0;
        seen_cyc   = 2'b00;
        @(posedge clk); #1;
        apb_i.paddr   = addr;
        apb_i.pwrite  = wr;
        apb_i.pwdata  = wdata;
        apb_i.pstrb   = strb;
        apb_i.psel    = 1'b1;
        apb_i.penable = 1'b0;
        @(posedge clk); #1;
        apb_i.penable = 1'b1;
        n = 1;
        @(negedge clk);
        while (!apb_i.pready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!apb_i.pready) begin
            check("pready_wait", 64'd0, 64'd1);
            exp_q.delete();
        end else begin
            check("latency", 64'(n), 64'(exp_lat));
            check("cyc_cycles", 64'(cyc_cycles), 64'(exp_cyc));
        end
        @(posedge clk); #1;
        apb_i.psel    = 1'b0;
        apb_i.penable = 1'b0;
        @(negedge clk);
        check("pready_one_clk", 64'(apb_i.pready), 64'd0);
        check("prdata_idle", 64'(apb_i.prdata), 64'd0);
        check("pslverr_idle", 64'(apb_i.pslverr), 64'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        apb_i.paddr = 32'h0; apb_i.psel = 1'b0; apb_i.penable = 1'b0;
        apb_i.pwrite = 1'b0; apb_i.pwdata = 32'h0; apb_i.pstrb = 4'h0;
        repeat (3) @(posedge clk);
        cur_tag = "reset";
        @(negedge clk);
        check("pready", 64'(apb_i.pready), 64'd0);
        check("prdata", 64'(apb_i.prdata), 64'd0);
        check("pslverr", 64'(apb_i.pslverr), 64'd0);
        check("cyc", 64'(wb_i.wb_cyc_o), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("cyc_after", 64'(wb_i.wb_cyc_o), 64'd0);

        cur_tag = "read_s1";
        wb_i.wb_dat_i = {32'hDEAD_BEEF, 32'h0BAD_F00D};
        resp_mode = M_ACK; resp_delay = 2;
        apb_xfer(32'h2610_0004, 1'b0, 32'h0, 4'h0, 1'b0, 32'hDEAD_BEEF, 5, 3);
        check("seen_cyc", 64'(seen_cyc), 64'd2);
        check("adr", 64'(cap_adr), 64'h2610_0004);
        check("we", 64'(cap_we), 64'd0);
        check("sel", 64'(cap_sel), 64'hF);

        cur_tag = "read_s0_min";
        resp_delay = 0;
        apb_xfer(32'h2600_0008, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0BAD_F00D, 3, 1);
        check("seen_cyc", 64'(seen_cyc), 64'd1);

        cur_tag = "write_s0";
        apb_xfer(32'h2600_0010, 1'b1, 32'h1234_5678, 4'b0011, 1'b0, 32'h0, 3, 1);
        check("seen_cyc_lowest", 64'(seen_cyc), 64'd1);
        check("we", 64'(cap_we), 64'd1);
        check("sel", 64'(cap_sel), 64'h3);
        check("dat", 64'(cap_dat), 64'h1234_5678);

        cur_tag = "wide_mask_s1";
        wb_i.wb_dat_i = {32'hA5A5_0001, 32'h5A5A_0000};
        apb_xfer(32'h26F0_0000, 1'b0, 32'h0, 4'h0, 1'b0, 32'hA5A5_0001, 3, 1);
        check("seen_cyc", 64'(seen_cyc), 64'd2);

        cur_tag = "miss";
        apb_xfer(32'h3000_0000, 1'b0, 32'h0, 4'h0, 1'b1, 32'h0, 2, 0);
        check("seen_cyc", 64'(seen_cyc), 64'd0);

        cur_tag = "err_s1";
        resp_mode = M_ERR; resp_delay = 1;
        apb_xfer(32'h2610_0000, 1'b0, 32'h0, 4'h0, 1'b1, 32'h0, 4, 2);

        cur_tag = "ack_err_s0";
        resp_mode = M_BOTH; resp_delay = 0;
        apb_xfer(32'h2600_0000, 1'b0, 32'h0, 4'h0, 1'b1, 32'h0, 3, 1);

        cur_tag = "stray";
        resp_mode = M_ACK; resp_delay = 3; stray_en = 1'b1;
        apb_xfer(32'h2600_0004, 1'b0, 32'h0, 4'h0, 1'b0, 32'h5A5A_0000, 6, 4);
        stray_en = 1'b0;

`ifdef APB_WB_BRIDGE_TIMEOUT_EN
        cur_tag = "timeout";
        resp_mode = M_NEVER;
        apb_xfer(32'h2600_0000, 1'b0, 32'h0, 4'h0, 1'b1, 32'h0, 6, 4);
        cur_tag = "ack_at_expiry";
        resp_mode = M_ACK; resp_delay = 3;
        apb_xfer(32'h2610_0000, 1'b0, 32'h0, 4'h0, 1'b0, 32'hA5A5_0001, 6, 4);
`else
        cur_tag = "no_timeout";
        resp_mode = M_ACK; resp_delay = 20;
        apb_xfer(32'h2600_0000, 1'b0, 32'h0, 4'h0, 1'b0, 32'h5A5A_0000, 23, 21);
`endif

        cur_tag = "psel_drop";
        resp_mode = M_ACK; resp_delay = 4;
        cyc_cycles = 0;
        @(posedge clk); #1;
        apb_i.paddr = 32'h2600_0020; apb_i.pwrite = 1'b0; apb_i.psel = 1'b1; apb_i.penable = 1'b0;
        @(posedge clk); #1 apb_i.penable = 1'b1;
        @(posedge clk); #1;
        apb_i.psel = 1'b0; apb_i.penable = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("no_pready", 64'(apb_i.pready), 64'd0);
        end
        check("prdata_zero", 64'(apb_i.prdata), 64'd0);
        check("cyc_completed", 64'(cyc_cycles), 64'd5);
        check("cyc_dropped", 64'(wb_i.wb_cyc_o), 64'd0);

        cur_tag = "rst_mid";
        resp_mode = M_NEVER;
        @(posedge clk); #1;
        apb_i.paddr = 32'h2600_0000; apb_i.psel = 1'b1; apb_i.penable = 1'b0;
        @(posedge clk); #1 apb_i.penable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("cyc_before", 64'(wb_i.wb_cyc_o), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check("cyc", 64'(wb_i.wb_cyc_o), 64'd0);
        check("stb", 64'(wb_i.wb_stb_o), 64'd0);
        check("pready", 64'(apb_i.pready), 64'd0);
        apb_i.psel = 1'b0; apb_i.penable = 1'b0;
        @(posedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
        resp_mode = M_ACK; resp_delay = 0;
        cur_tag = "after_rst";
        apb_xfer(32'h2610_0008, 1'b0, 32'h0, 4'h0, 1'b0, 32'hA5A5_0001, 3, 1);

        cur_tag = "end";
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/apb_wb_bridge_n.md
APB_WB_BRIDGE_N -- requirements
Module: apb_wb_bridge_n

Interface
REQ-001 SHALL have parameter N_SLAVES, default 2, number of Wishbone master ports (1..8).
REQ-002 SHALL have parameter W_ADDR, default 32, address width.
REQ-003 SHALL have parameter W_DATA, default 32, data width (32 or 64).
REQ-004 SHALL have parameter ADDR_MAP, default {32'h26100000,32'h26000000}, per-slave base (N_SLAVES*W_ADDR bits, slave 0 in LSBs).
REQ-005 SHALL have parameter ADDR_MASK, default {32'hFFF00000,32'hFFF00000}, per-slave decode mask.
REQ-006 SHALL have parameter TIMEOUT_CYCLES, default 255, Wishbone wait limit in clocks (1..65535).
REQ-007 SHALL have ports: clk input 1, sole clock; rst_n input 1, asynchronous active-low reset.
REQ-008 SHALL have APB slave ports: paddr in W_ADDR; psel in 1; penable in 1; pwrite in 1; pwdata in W_DATA; pstrb in W_DATA/8; pready out 1; prdata out W_DATA; pslverr out 1.
REQ-009 SHALL have Wishbone master ports: wb_cyc_o out N_SLAVES; wb_stb_o out N_SLAVES; wb_we_o out 1; wb_sel_o out W_DATA/8; wb_adr_o out W_ADDR; wb_dat_o out W_DATA; wb_dat_i in N_SLAVES*W_DATA; wb_ack_i in N_SLAVES; wb_err_i in N_SLAVES.

Function
REQ-010 SHALL implement FSM IDLE, WB_WAIT, RESP.
REQ-011 IDLE: on psel&penable, SHALL decode paddr; hit -> latch addr/data/we/strb, select index, go WB_WAIT; miss -> go RESP with pslverr=1, prdata=0.
REQ-012 Decode SHALL hit slave i when (paddr & mask_i) == (map_i & mask_i); multiple hits SHALL select the lowest index.
REQ-013 WB_WAIT: SHALL drive registered wb_cyc_o[i]=wb_stb_o[i]=1 for the selected slave only; all other bits 0.
REQ-014 wb_sel_o SHALL equal latched pstrb on writes and all-ones on reads.
REQ-015 On wb_ack_i[i] or wb_err_i[i], SHALL deassert cyc/stb next clock, capture wb_dat_i slice i (read) or 0 (write), go RESP.
REQ-016 Simultaneous ack and err SHALL be treated as error (pslverr=1, prdata=0).
REQ-017 RESP: SHALL drive pready=1 for exactly one clock with registered prdata/pslverr, then return to IDLE.
REQ-018 pready SHALL be 0 in IDLE and WB_WAIT; prdata and pslverr SHALL be 0 whenever pready=0.
REQ-019 Minimum latency: pready high on the 3rd access-phase clock when the slave acks in its first stb cycle.
REQ-020 If psel drops during WB_WAIT, SHALL complete the Wishbone cycle, discard the result, return to IDLE without pready.
REQ-021 Ack/err on unselected ports SHALL be ignored.

Reset
REQ-022 On rst_n low, SHALL asynchronously force IDLE, wb_cyc_o=wb_stb_o=0, pready=0, pslverr=0, prdata=0, all latches and timeout counter 0, including mid-transfer.

Configuration
REQ-023 With APB_WB_BRIDGE_TIMEOUT_EN defined, SHALL count clocks in WB_WAIT; at TIMEOUT_CYCLES without ack/err, SHALL drop cyc/stb, go RESP with pslverr=1, prdata=0.
REQ-024 An ack arriving on the expiry clock SHALL win over timeout.
REQ-025 Without APB_WB_BRIDGE_TIMEOUT_EN, SHALL wait indefinitely, and no counter SHALL be synthesised.

Structure
REQ-026 Package apb_wb_pkg SHALL hold the FSM state enum, max-slave constant (8), and a default-mask constant.
REQ-027 Address decode SHALL be a sub-module apb_wb_decoder (one-hot hit vector plus index, combinational).

Verification
REQ-028 Read slave 1 at 0x26100004, ack after 2 clocks, wb_dat_i=0xDEADBEEF -> prdata=0xDEADBEEF, pslverr=0, only wb_cyc_o[1] high.
REQ-029 Write 0x26000010 data 0x12345678, pstrb=4'b0011 -> wb_we_o=1, wb_sel_o=4'b0011, wb_dat_o=0x12345678, pready one clock.
REQ-030 Access 0x30000000 -> no wb_cyc_o asserted, pready=1, pslverr=1 on 2nd access clock.
REQ-031 TIMEOUT_CYCLES=4, macro defined, slave never acks -> cyc/stb drop after 4 clocks, pslverr=1, prdata=0.
REQ-032 ack and err together on slave 0 -> pslverr=1, prdata=0; separately, rst_n low during WB_WAIT -> cyc/stb 0 immediately, next transfer succeeds.
